div_seq_ctrl: RTL and testbench
===============================

// Module: div_seq_ctrl
// PURPOSE
// Sequencing controller for the keypad divider path. Assembles operands A and B from hex keypad nibbles.
// Drives the divider through a start/done handshake and guards it with a watchdog.
// Then sequences bin2bcd on the quotient and latches results for the 7-seg display.
// Sits between keypad decoder and divider / bin2bcd / display_7seg.
// PARAMETERS
// W           8    operand/quotient/remainder width; multiple of 4
// NDIG        2    nibbles per operand (NDIG*4 == W)
// TIMEOUT_CYC 64   max cycles waiting for div_done before error
// PORTS
// clk         in   1     system clock, single domain
// rst         in   1     synchronous, active-low reset
// key_valid   in   1     one-cycle pulse: new key on key_code
// key_code    in   4     hex key value
// clr         in   1     abort/clear pulse, any state
// div_start   out  1     one-cycle start pulse to divider
// div_a       out  W     dividend; stable from div_start until div_done
// div_b       out  W     divisor; stable from div_start until div_done
// div_done    in   1     one-cycle pulse: div_q/div_r valid this cycle
// div_q       in   W     quotient
// div_r       in   W     remainder
// bcd_start   out  1     one-cycle start pulse to bin2bcd
// bcd_bin     out  W     value to convert
// bcd_done    in   1     conversion finished
// bcd_in      in   16    bin2bcd digits {bcd3,bcd2,bcd1,bcd0}
// disp_q      out  16   latched quotient BCD for display
// res_valid   out  1     result valid, held until next entry/clr
// res_q       out  W     latched quotient
// res_r       out  W     latched remainder
// err_div0    out  1     B==0 entered; held until next key/clr
// err_tmo     out  1     divider watchdog expired; held until next key/clr
// state_dbg   out  3     current state encoding
// BEHAVIOUR
// - All outputs registered; reset (rst==0 at posedge) -> state ENT_A, all outputs 0, nibble count 0.
// - States: ENT_A, ENT_B, DIV_GO, DIV_WAIT, BCD_GO, BCD_WAIT, SHOW, ERR.
// - ENT_A/ENT_B: key_valid shifts key_code into the operand LSBs ({op[W-5:0],key}) and increments the count.
//   On the NDIG-th nibble of A -> ENT_B, count 0.
//   On the NDIG-th nibble of B -> DIV_GO; if the completed B==0 -> ERR with err_div0=1, no div_start.
// - DIV_GO: div_start=1 exactly one cycle (Moore) -> DIV_WAIT; watchdog cleared to 0.
// - DIV_WAIT: div_done -> latch res_q<=div_q, res_r<=div_r -> BCD_GO.
//   Watchdog reaching TIMEOUT_CYC-1 without done -> ERR, err_tmo=1. Done in the expiry cycle wins.
// - BCD_GO: bcd_start=1 one cycle, bcd_bin=res_q -> BCD_WAIT.
// - BCD_WAIT: bcd_done -> disp_q<=bcd_in, res_valid<=1 -> SHOW.
// - SHOW/ERR: key_valid clears res_valid/err_*; that key is the first nibble of new A (count=1) -> ENT_A.
// - key_valid in DIV_GO..BCD_WAIT is ignored (dropped, no queueing).
// - clr has top priority in every state: -> ENT_A, operands/count/res_*/err_*/disp_q zeroed.
//   A div_done/bcd_done arriving after clr is ignored.
// - key_valid coincident with clr: clr wins, key dropped.
// - div_a/div_b change only in ENT_A/ENT_B; never while divider busy.
// CONFIGURATION
// - DIVCTL_REM_EN defined: after quotient BCD, states BCD_GO_R/BCD_WAIT_R convert res_r.
//   Result goes to extra output disp_r[15:0]; res_valid rises only after both conversions.
// - Undefined: no disp_r port, no remainder conversion, res_valid after the quotient conversion.
// STRUCTURE
// - Package divctl_pkg: state enum divctl_st_t, err code enum, default TIMEOUT_CYC constant.
// - Sub-module div_watchdog: clear/enable counter with expire flag, parameter TIMEOUT_CYC.
// TESTING
// - Keys 6,4,0,7 -> div_a=0x64, div_b=0x07, single div_start.
//   Stub returns q=14,r=2 after 8 cycles -> bcd_start with bcd_bin=14, res_q=0x0E, res_r=0x02, res_valid=1.
// - Keys 1,2,0,0 -> err_div0=1, div_start never pulses; next key 3 -> err_div0=0, ENT_A with A nibble 3.
// - Stub never asserts div_done -> err_tmo=1 exactly TIMEOUT_CYC cycles after div_start.
// - clr during DIV_WAIT, stub div_done 3 cycles later -> state ENT_A, res_valid=0, no bcd_start.
// - key_valid during BCD_WAIT -> ignored; key 9 in SHOW -> res_valid=0, state ENT_A, count=1.
// - rst low mid-ENT_B (after A=0xFF, one B nibble) -> all outputs 0, state ENT_A.

Source files
------------

// File: rtl/divctl_pkg.sv
// Shared types for the keypad divider sequencing controller.
// DIVCTL_REM_EN widens the state encoding to make room for the remainder conversion states.
package divctl_pkg;

    localparam int DIVCTL_TIMEOUT_DEF = 64;

`ifdef DIVCTL_REM_EN
    typedef enum logic [3:0] {
        ENT_A      = 4'd0,
        ENT_B      = 4'd1,
        DIV_GO     = 4'd2,
        DIV_WAIT   = 4'd3,
        BCD_GO     = 4'd4,
        BCD_WAIT   = 4'd5,
        SHOW       = 4'd6,
        ERR        = 4'd7,
        BCD_GO_R   = 4'd8,
        BCD_WAIT_R = 4'd9
    } divctl_st_t;
`else
    typedef enum logic [2:0] {
        ENT_A    = 3'd0,
        ENT_B    = 3'd1,
        DIV_GO   = 3'd2,
        DIV_WAIT = 3'd3,
        BCD_GO   = 3'd4,
        BCD_WAIT = 3'd5,
        SHOW     = 3'd6,
        ERR      = 3'd7
    } divctl_st_t;
`endif

    // Bit 0 and bit 1 map straight onto err_div0 / err_tmo.
    typedef enum logic [1:0] {
        DERR_NONE = 2'b00,
        DERR_DIV0 = 2'b01,
        DERR_TMO  = 2'b10
    } divctl_err_t;

endpackage

// File: rtl/div_watchdog.sv
// Divider watchdog: cycle counter with synchronous clear and count enable.
// expire fires on the enabled cycle whose increment steps the count onto TIMEOUT_CYC-1.
module div_watchdog #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT_CYC);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = en && !clr && (cnt_q == CW'(TIMEOUT_CYC - 2));

endmodule

// File: rtl/div_seq_ctrl.sv
// Keypad divider sequencer: operand entry, divider handshake with watchdog, BCD conversion, result latch.
// Define DIVCTL_REM_EN to also convert the remainder and expose it on disp_r.
module div_seq_ctrl
    import divctl_pkg::*;
#(
    parameter int W           = 8,
    parameter int NDIG        = 2,
    parameter int TIMEOUT_CYC = DIVCTL_TIMEOUT_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_valid,
    input  logic [3:0]   key_code,
    input  logic         clr,
    output logic         div_start,
    output logic [W-1:0] div_a,
    output logic [W-1:0] div_b,
    input  logic         div_done,
    input  logic [W-1:0] div_q,
    input  logic [W-1:0] div_r,
    output logic         bcd_start,
    output logic [W-1:0] bcd_bin,
    input  logic         bcd_done,
    input  logic [15:0]  bcd_in,
    output logic [15:0]  disp_q,
    output logic         res_valid,
    output logic [W-1:0] res_q,
    output logic [W-1:0] res_r,
    output logic         err_div0,
    output logic         err_tmo,
`ifdef DIVCTL_REM_EN
    output logic [15:0]  disp_r,
`endif
    output logic [2:0]   state_dbg
);

    localparam int CNT_W = $clog2(NDIG + 1);

    divctl_st_t    st_q, st_d;
    divctl_err_t   err_q, err_d;
    logic [W-1:0]  op_a_q, op_a_d, op_b_q, op_b_d;
    logic [W-1:0]  res_q_q, res_q_d, res_r_q, res_r_d, bcd_bin_q, bcd_bin_d;
    logic [CNT_W-1:0] nib_cnt_q, nib_cnt_d;
    logic [15:0]   disp_q_q, disp_q_d;
    logic          div_start_q, div_start_d, bcd_start_q, bcd_start_d;
    logic          res_valid_q, res_valid_d;
`ifdef DIVCTL_REM_EN
    logic [15:0]   disp_r_q, disp_r_d;
`endif

    logic          wd_clr, wd_en, wd_expire;
    logic [W-1:0]  key_a, key_b;
    logic          nib_last;

    div_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wd (
        .clk    (clk),
        .rst    (rst),
        .clr    (wd_clr),
        .en     (wd_en),
        .expire (wd_expire)
    );

    assign key_a    = {op_a_q[W-5:0], key_code};
    assign key_b    = {op_b_q[W-5:0], key_code};
    assign nib_last = (nib_cnt_q == CNT_W'(NDIG - 1));

    always_comb begin
        st_d        = st_q;
        err_d       = err_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        nib_cnt_d   = nib_cnt_q;
        res_q_d     = res_q_q;
        res_r_d     = res_r_q;
        bcd_bin_d   = bcd_bin_q;
        disp_q_d    = disp_q_q;
        res_valid_d = res_valid_q;
`ifdef DIVCTL_REM_EN
        disp_r_d    = disp_r_q;
`endif
        wd_clr      = 1'b0;
        wd_en       = 1'b0;

        unique case (st_q)
            ENT_A: if (key_valid) begin
                op_a_d = key_a;
                if (nib_last) begin
                    nib_cnt_d = '0;
                    st_d      = ENT_B;
                end else begin
                    nib_cnt_d = nib_cnt_q + CNT_W'(1);
                end
            end
            ENT_B: if (key_valid) begin
                op_b_d = key_b;
                if (nib_last) begin
                    nib_cnt_d = '0;
                    if (key_b == '0) begin
                        st_d  = ERR;
                        err_d = DERR_DIV0;
                    end else begin
                        st_d  = DIV_GO;
                    end
                end else begin
                    nib_cnt_d = nib_cnt_q + CNT_W'(1);
                end
            end
            DIV_GO: begin
                wd_clr = 1'b1;
                st_d   = DIV_WAIT;
            end
            DIV_WAIT: begin
                wd_en = 1'b1;
                // A done arriving on the expiry cycle still counts as success.
                if (div_done) begin
                    res_q_d   = div_q;
                    res_r_d   = div_r;
                    bcd_bin_d = div_q;
                    st_d      = BCD_GO;
                end else if (wd_expire) begin
                    err_d = DERR_TMO;
                    st_d  = ERR;
                end
            end
            BCD_GO: st_d = BCD_WAIT;
            BCD_WAIT: if (bcd_done) begin
                disp_q_d = bcd_in;
`ifdef DIVCTL_REM_EN
                bcd_bin_d = res_r_q;
                st_d      = BCD_GO_R;
`else
                res_valid_d = 1'b1;
                st_d        = SHOW;
`endif
            end
`ifdef DIVCTL_REM_EN
            BCD_GO_R: st_d = BCD_WAIT_R;
            BCD_WAIT_R: if (bcd_done) begin
                disp_r_d    = bcd_in;
                res_valid_d = 1'b1;
                st_d        = SHOW;
            end
`endif
            SHOW, ERR: if (key_valid) begin
                res_valid_d = 1'b0;
                err_d       = DERR_NONE;
                op_a_d      = {{(W-4){1'b0}}, key_code};
                op_b_d      = '0;
                nib_cnt_d   = CNT_W'(1);
                st_d        = ENT_A;
            end
            default: st_d = ENT_A;
        endcase

        if (clr) begin
            st_d        = ENT_A;
            err_d       = DERR_NONE;
            op_a_d      = '0;
            op_b_d      = '0;
            nib_cnt_d   = '0;
            res_q_d     = '0;
            res_r_d     = '0;
            bcd_bin_d   = '0;
            disp_q_d    = '0;
            res_valid_d = 1'b0;
`ifdef DIVCTL_REM_EN
            disp_r_d    = '0;
`endif
        end

        // Start strobes are registered so they are high exactly while in the GO states.
        div_start_d = (st_d == DIV_GO);
`ifdef DIVCTL_REM_EN
        bcd_start_d = (st_d == BCD_GO) || (st_d == BCD_GO_R);
`else
        bcd_start_d = (st_d == BCD_GO);
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            st_q        <= ENT_A;
            err_q       <= DERR_NONE;
            op_a_q      <= '0;
            op_b_q      <= '0;
            nib_cnt_q   <= '0;
            res_q_q     <= '0;
            res_r_q     <= '0;
            bcd_bin_q   <= '0;
            disp_q_q    <= '0;
            res_valid_q <= 1'b0;
            div_start_q <= 1'b0;
            bcd_start_q <= 1'b0;
`ifdef DIVCTL_REM_EN
            disp_r_q    <= '0;
`endif
        end else begin
            st_q        <= st_d;
            err_q       <= err_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            nib_cnt_q   <= nib_cnt_d;
            res_q_q     <= res_q_d;
            res_r_q     <= res_r_d;
            bcd_bin_q   <= bcd_bin_d;
            disp_q_q    <= disp_q_d;
            res_valid_q <= res_valid_d;
            div_start_q <= div_start_d;
            bcd_start_q <= bcd_start_d;
`ifdef DIVCTL_REM_EN
            disp_r_q    <= disp_r_d;
`endif
        end
    end

    assign div_start = div_start_q;
    assign div_a     = op_a_q;
    assign div_b     = op_b_q;
    assign bcd_start = bcd_start_q;
    assign bcd_bin   = bcd_bin_q;
    assign disp_q    = disp_q_q;
    assign res_valid = res_valid_q;
    assign res_q     = res_q_q;
    assign res_r     = res_r_q;
    assign err_div0  = err_q[0];
    assign err_tmo   = err_q[1];
`ifdef DIVCTL_REM_EN
    assign disp_r    = disp_r_q;
    assign state_dbg = st_q[2:0];
`else
    assign state_dbg = st_q;
`endif

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed bench for div_seq_ctrl: entry, divide, div-by-zero, watchdog, clr and reset scenarios.
module tb_div_seq_ctrl;

    localparam int W   = 8;
    localparam int TMO = 64;

    localparam logic [2:0] S_ENT_A = 3'd0, S_ENT_B = 3'd1, S_DIV_GO = 3'd2, S_DIV_WAIT = 3'd3,
                           S_BCD_GO = 3'd4, S_BCD_WAIT = 3'd5, S_SHOW = 3'd6, S_ERR = 3'd7;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         key_valid = 1'b0;
    logic [3:0]   key_code = '0;
    logic         clr = 1'b0;
    logic         div_start;
    logic [W-1:0] div_a, div_b;
    logic         div_done = 1'b0;
    logic [W-1:0] div_q = '0, div_r = '0;
    logic         bcd_start;
    logic [W-1:0] bcd_bin;
    logic         bcd_done = 1'b0;
    logic [15:0]  bcd_in = '0;
    logic [15:0]  disp_q;
    logic         res_valid;
    logic [W-1:0] res_q, res_r;
    logic         err_div0, err_tmo;
`ifdef DIVCTL_REM_EN
    logic [15:0]  disp_r;
`endif
    logic [2:0]   state_dbg;

    int n_chk  = 0;
    int n_pass = 0;
    int ds_cnt = 0;
    int bs_cnt = 0;

    div_seq_ctrl #(.W(W), .NDIG(2), .TIMEOUT_CYC(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_code  (key_code),
        .clr       (clr),
        .div_start (div_start),
        .div_a     (div_a),
        .div_b     (div_b),
        .div_done  (div_done),
        .div_q     (div_q),
        .div_r     (div_r),
        .bcd_start (bcd_start),
        .bcd_bin   (bcd_bin),
        .bcd_done  (bcd_done),
        .bcd_in    (bcd_in),
        .disp_q    (disp_q),
        .res_valid (res_valid),
        .res_q     (res_q),
        .res_r     (res_r),
        .err_div0  (err_div0),
        .err_tmo   (err_tmo),
`ifdef DIVCTL_REM_EN
        .disp_r    (disp_r),
`endif
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (div_start) ds_cnt++;
        if (bcd_start) bs_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic key(input logic [3:0] k);
        key_valid = 1'b1;
        key_code  = k;
        tick();
        key_valid = 1'b0;
    endtask

    initial begin
        int ds0, bs0, seen;

        // Reset state
        tick(); tick();
        chk("rst_state", state_dbg, S_ENT_A);
        chk("rst_div_a", div_a, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_starts", {div_start, bcd_start}, 0);
        rst = 1'b1;
        tick();

        // 0x64 / 0x07
        key(4'h6);
        chk("a_nib1", div_a, 8'h06);
        key(4'h4);
        chk("a_full", div_a, 8'h64);
        chk("st_ent_b", state_dbg, S_ENT_B);
        key(4'h0);
        key(4'h7);
        chk("b_full", div_b, 8'h07);
        chk("st_div_go", state_dbg, S_DIV_GO);
        chk("div_start_hi", div_start, 1);
        tick();
        chk("div_start_lo", div_start, 0);
        chk("st_div_wait", state_dbg, S_DIV_WAIT);
        repeat (6) tick();
        div_done = 1'b1; div_q = 8'd14; div_r = 8'd2;
        tick();
        div_done = 1'b0; div_q = '0; div_r = '0;
        chk("st_bcd_go", state_dbg, S_BCD_GO);
        chk("bcd_start_hi", bcd_start, 1);
        chk("bcd_bin", bcd_bin, 8'd14);
        chk("res_q", res_q, 8'h0E);
        chk("res_r", res_r, 8'h02);
        tick();
        chk("st_bcd_wait", state_dbg, S_BCD_WAIT);
        key(4'h5);
        chk("key_ign_state", state_dbg, S_BCD_WAIT);
        chk("key_ign_a", div_a, 8'h64);
        bcd_done = 1'b1; bcd_in = 16'h0014;
        tick();
        bcd_done = 1'b0; bcd_in = '0;
        chk("st_show", state_dbg, S_SHOW);
        chk("res_valid", res_valid, 1);
        chk("disp_q", disp_q, 16'h0014);
        chk("div_start_once", ds_cnt, 1);
        chk("bcd_start_once", bs_cnt, 1);

        // New entry from SHOW: key is first A nibble
        key(4'h9);
        chk("show_key_state", state_dbg, S_ENT_A);
        chk("show_key_rv", res_valid, 0);
        chk("show_key_a", div_a, 8'h09);
        key(4'h1);
        chk("show_cnt1", {5'd0, state_dbg, div_a}, {8'd0, S_ENT_B, 8'h91});

        // Divide by zero
        clr = 1'b1; tick(); clr = 1'b0;
        chk("clr_state", state_dbg, S_ENT_A);
        chk("clr_res_q", res_q, 0);
        ds0 = ds_cnt;
        key(4'h1); key(4'h2); key(4'h0); key(4'h0);
        chk("div0_state", state_dbg, S_ERR);
        chk("div0_flag", err_div0, 1);
        tick(); tick();
        chk("div0_no_start", ds_cnt, ds0);
        key(4'h3);
        chk("div0_clear", err_div0, 0);
        chk("div0_new_st", state_dbg, S_ENT_A);
        chk("div0_new_a", div_a, 8'h03);

        // Watchdog timeout: 0x35 / 0x02, divider never answers
        key(4'h5); key(4'h0); key(4'h2);
        chk("tmo_div_go", div_start, 1);
        seen = -1;
        for (int i = 1; i <= TMO + 4; i++) begin
            tick();
            if (err_tmo && seen < 0) seen = i;
        end
        chk("tmo_latency", seen, TMO);
        chk("tmo_state", state_dbg, S_ERR);
        key(4'h8);
        chk("tmo_clear", err_tmo, 0);

        // Done on the expiry cycle wins: 0x84 / 0x03
        key(4'h4); key(4'h0); key(4'h3);
        chk("exp_div_go", state_dbg, S_DIV_GO);
        repeat (TMO - 1) tick();
        div_done = 1'b1; div_q = 8'h2C; div_r = 8'h00;
        tick();
        div_done = 1'b0; div_q = '0;
        chk("exp_win_state", state_dbg, S_BCD_GO);
        chk("exp_win_tmo", err_tmo, 0);
        chk("exp_win_res_q", res_q, 8'h2C);
        tick();
        bcd_done = 1'b1; bcd_in = 16'h0044;
        tick();
        bcd_done = 1'b0; bcd_in = '0;
        chk("exp_win_disp", {res_valid, disp_q}, {1'b1, 16'h0044});

        // clr during DIV_WAIT, late done ignored
        key(4'h1); key(4'h0); key(4'h0); key(4'h5);
        tick();
        chk("clr_dw_state", state_dbg, S_DIV_WAIT);
        clr = 1'b1; tick(); clr = 1'b0;
        bs0 = bs_cnt;
        tick(); tick();
        div_done = 1'b1; div_q = 8'h33; div_r = 8'h01;
        tick();
        div_done = 1'b0; div_q = '0; div_r = '0;
        tick(); tick();
        chk("clr_dw_st", state_dbg, S_ENT_A);
        chk("clr_dw_rv", res_valid, 0);
        chk("clr_dw_res", res_q, 0);
        chk("clr_dw_no_bcd", bs_cnt, bs0);

        // clr and key together: key dropped
        clr = 1'b1; key_valid = 1'b1; key_code = 4'h7;
        tick();
        clr = 1'b0; key_valid = 1'b0;
        chk("clr_key_a", div_a, 0);

        // Reset in the middle of ENT_B
        key(4'hF); key(4'hF); key(4'h1);
        chk("rst_mid_pre", {state_dbg, div_a, div_b}, {S_ENT_B, 8'hFF, 8'h01});
        rst = 1'b0; tick(); rst = 1'b1;
        chk("rst_mid_state", state_dbg, S_ENT_A);
        chk("rst_mid_ops", {div_a, div_b}, 0);
        chk("rst_mid_flags", {res_valid, err_div0, err_tmo, div_start, bcd_start}, 0);
        chk("rst_mid_cnt", 32'(div_a), 0);
        key(4'h2); key(4'h5);
        chk("rst_mid_cnt0", {state_dbg, div_a}, {S_ENT_B, 8'h25});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
